// File: rtl/qupls4_const_decode_pipe.sv
// Two-stage constant extractor for the Qupls4 decode stage: S1 slices raw constant
// fields out of each lane's window, S2 sign-extends or FP-widens them for rename.
module qupls4_const_decode_pipe #(
    parameter int          LANES     = 4,
    parameter int          RAW_W     = 240,
    parameter int          XLEN      = 64,
    parameter int          NCONST    = 3,
    parameter int          FP_CONV   = 1,
    parameter logic [31:0] CNT_RESET = 32'd0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [LANES*RAW_W-1:0]         in_raw,
    input  logic [LANES*NCONST*4-1:0]      in_pos,
    input  logic [LANES*NCONST*2-1:0]      in_isz,
    input  logic [LANES*NCONST-1:0]        in_has,
    input  logic [LANES*NCONST-1:0]        in_fp,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [LANES*NCONST*XLEN-1:0]   out_imm,
    output logic [LANES*NCONST-1:0]        out_has,
    output logic [LANES*NCONST-1:0]        out_oob,
    output logic [31:0]                    const_cnt
);
    localparam int NS = LANES * NCONST;

    // Handshake: a group moves across a boundary on the rising edge where the sender's
    // valid and the receiver's ready are both high; ready never looks at valid.
    logic                      s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [NS-1:0][63:0]       s1_field_q, s1_field_d;
    logic [NS-1:0][1:0]        s1_isz_q, s1_isz_d;
    logic [NS-1:0]             s1_has_q, s1_has_d, s1_fp_q, s1_fp_d, s1_oob_q, s1_oob_d;
    logic [NS-1:0][XLEN-1:0]   s2_imm_q, s2_imm_d;
    logic [NS-1:0]             s2_has_q, s2_has_d, s2_oob_q, s2_oob_d;
    logic [31:0]               cnt_q, cnt_d;
    logic [NS-1:0][3:0]        pos_a;
    logic [NS-1:0][1:0]        isz_a;
    logic                      s2_ready, accept, out_xfer;
    logic [32:0]               cnt_sum;

    assign pos_a = in_pos;
    assign isz_a = in_isz;

    function automatic logic [63:0] extract(input logic [RAW_W-1:0] raw,
                                            input logic [3:0] pos, input logic [1:0] isz);
        logic [RAW_W-1:0] sh;
        logic [63:0]      mask;
        sh = raw >> {pos, 4'b0000};
        case (isz)
            2'd0:    mask = 64'h0000_0000_0000_00FF;
            2'd1:    mask = 64'h0000_0000_0000_FFFF;
            2'd2:    mask = 64'h0000_0000_FFFF_FFFF;
            default: mask = '1;
        endcase
        return sh[63:0] & mask;
    endfunction

    function automatic logic past_end(input logic [3:0] pos, input logic [1:0] isz);
        logic [9:0] end_bit;
        end_bit = {2'b00, pos, 4'b0000} + (10'd8 << isz);
        return end_bit > 10'(RAW_W);
    endfunction

    function automatic logic [63:0] sext(input logic [63:0] f, input logic [1:0] isz);
        case (isz)
            2'd0:    return {{56{f[7]}}, f[7:0]};
            2'd1:    return {{48{f[15]}}, f[15:0]};
            2'd2:    return {{32{f[31]}}, f[31:0]};
            default: return f;
        endcase
    endfunction

    // Subnormal inputs are normalised: every half/single subnormal is a normal double.
    function automatic logic [63:0] half_to_double(input logic [15:0] h);
        logic [10:0] mm;
        int          k;
        k = 0;
        for (int b = 0; b < 10; b++) if (h[b]) k = b;
        mm = {1'b0, h[9:0]} << (10 - k);
        if (h[14:10] == 5'd0)
            return (h[9:0] == 10'd0) ? {h[15], 63'd0} : {h[15], 11'(k + 999), mm[9:0], 42'd0};
        else if (h[14:10] == 5'h1F)
            return {h[15], 11'h7FF, h[9:0], 42'd0};
        else
            return {h[15], 11'(h[14:10]) + 11'd1008, h[9:0], 42'd0};
    endfunction

    function automatic logic [63:0] single_to_double(input logic [31:0] s);
        logic [23:0] mm;
        int          k;
        k = 0;
        for (int b = 0; b < 23; b++) if (s[b]) k = b;
        mm = {1'b0, s[22:0]} << (23 - k);
        if (s[30:23] == 8'd0)
            return (s[22:0] == 23'd0) ? {s[31], 63'd0} : {s[31], 11'(k + 874), mm[22:0], 29'd0};
        else if (s[30:23] == 8'hFF)
            return {s[31], 11'h7FF, s[22:0], 29'd0};
        else
            return {s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'd0};
    endfunction

    function automatic logic [XLEN-1:0] fmt(input logic [63:0] f, input logic [1:0] isz,
                                            input logic fp);
        logic [63:0] r;
        if (fp && FP_CONV != 0) begin
            case (isz)
                2'd1:    r = half_to_double(f[15:0]);
                2'd2:    r = single_to_double(f[31:0]);
                2'd3:    r = f;
                default: r = sext(f, isz);
            endcase
        end else begin
            r = sext(f, isz);
        end
        return XLEN'($signed(r));
    endfunction

    always_comb begin
        s2_ready = !s2_valid_q || out_ready;
        in_ready = !rst && !flush && (!s1_valid_q || s2_ready);
        accept   = in_valid && in_ready;
        out_xfer = s2_valid_q && out_ready && !flush;

        s1_valid_d = s1_valid_q;
        s1_field_d = s1_field_q;
        s1_isz_d   = s1_isz_q;
        s1_has_d   = s1_has_q;
        s1_fp_d    = s1_fp_q;
        s1_oob_d   = s1_oob_q;
        s2_valid_d = s2_valid_q;
        s2_imm_d   = s2_imm_q;
        s2_has_d   = s2_has_q;
        s2_oob_d   = s2_oob_q;

        if (!s1_valid_q || s2_ready) s1_valid_d = accept;
        if (accept) begin
            for (int i = 0; i < NS; i++) begin
                s1_field_d[i] = extract(in_raw[(i / NCONST) * RAW_W +: RAW_W], pos_a[i], isz_a[i]);
                s1_oob_d[i]   = past_end(pos_a[i], isz_a[i]);
                s1_isz_d[i]   = isz_a[i];
            end
            s1_has_d = in_has;
            s1_fp_d  = in_fp;
        end

        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            for (int i = 0; i < NS; i++) begin
                s2_has_d[i] = s1_valid_q && s1_has_q[i] && !s1_oob_q[i];
                s2_oob_d[i] = s1_valid_q && s1_has_q[i] && s1_oob_q[i];
                s2_imm_d[i] = s2_has_d[i] ? fmt(s1_field_q[i], s1_isz_q[i], s1_fp_q[i]) : '0;
            end
        end

        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end

        cnt_sum = {1'b0, cnt_q} + 33'($countones(s2_has_q));
        cnt_d   = cnt_q;
        if (out_xfer) cnt_d = cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_field_q <= '0;
            s1_isz_q   <= '0;
            s1_has_q   <= '0;
            s1_fp_q    <= '0;
            s1_oob_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_imm_q   <= '0;
            s2_has_q   <= '0;
            s2_oob_q   <= '0;
            cnt_q      <= CNT_RESET;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_field_q <= s1_field_d;
            s1_isz_q   <= s1_isz_d;
            s1_has_q   <= s1_has_d;
            s1_fp_q    <= s1_fp_d;
            s1_oob_q   <= s1_oob_d;
            s2_valid_q <= s2_valid_d;
            s2_imm_q   <= s2_imm_d;
            s2_has_q   <= s2_has_d;
            s2_oob_q   <= s2_oob_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_imm   = s2_imm_q;
    assign out_has   = s2_has_q;
    assign out_oob   = s2_oob_q;
    assign const_cnt = cnt_q;
endmodule

// File: tb/tb_qupls4_const_decode_pipe.sv
// Directed bench for qupls4_const_decode_pipe: per-slot vector table, then streaming,
// backpressure, flush, mid-run reset and counter/saturation sequences.
module tb_qupls4_const_decode_pipe;
    localparam int LANES = 4, RAW_W = 240, XLEN = 64, NCONST = 3, NS = LANES * NCONST;
    localparam int IW = NS * XLEN;

    logic clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [LANES*RAW_W-1:0] in_raw;
    logic [NS*4-1:0]        in_pos;
    logic [NS*2-1:0]        in_isz;
    logic [NS-1:0]          in_has, in_fp, out_has, out_oob;
    logic [IW-1:0]          out_imm;
    logic [31:0]            const_cnt;
    logic                   sat_in_ready, sat_out_valid;
    logic [IW-1:0]          sat_out_imm;
    logic [NS-1:0]          sat_out_has, sat_out_oob;
    logic [31:0]            sat_cnt;

    qupls4_const_decode_pipe u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_raw(in_raw), .in_pos(in_pos), .in_isz(in_isz), .in_has(in_has), .in_fp(in_fp),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_has(out_has),
        .out_oob(out_oob), .const_cnt(const_cnt));

    // Second copy starts its counter just below the top so saturation is reachable.
    qupls4_const_decode_pipe #(.CNT_RESET(32'hFFFF_FFF0)) u_sat (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(sat_in_ready),
        .in_raw(in_raw), .in_pos(in_pos), .in_isz(in_isz), .in_has(in_has), .in_fp(in_fp),
        .out_valid(sat_out_valid), .out_ready(out_ready), .out_imm(sat_out_imm),
        .out_has(sat_out_has), .out_oob(sat_out_oob), .const_cnt(sat_cnt));

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  pos;
        logic [1:0]  isz;
        logic        has;
        logic        fp;
        logic [63:0] val;
        logic [63:0] exp_imm;
        logic        exp_has;
        logic        exp_oob;
    } vec_t;

    localparam int NV = 20;
    vec_t        vecs [NV];
    int          n_chk = 0, n_pass = 0;
    logic [31:0] exp_cnt = 0;
    logic [7:0]  exp_q[$];

    task automatic chk(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic clear_inputs();
        for (int l = 0; l < LANES; l++) in_raw[l*RAW_W +: RAW_W] = {15{16'hA5C3}};
        for (int i = 0; i < NS; i++) begin
            in_pos[i*4 +: 4] = 4'($urandom_range(0, 15));
            in_isz[i*2 +: 2] = 2'($urandom_range(0, 3));
        end
        in_has = '0;
        in_fp  = '0;
    endtask

    function automatic logic [15:0] grp_val(input int g, input int l, input int s);
        return 16'((g << 12) | (l << 8) | (s << 4) | 5);
    endfunction

    function automatic logic [IW-1:0] grp_exp(input int g);
        logic [IW-1:0] e;
        logic [15:0]   v;
        for (int l = 0; l < LANES; l++)
            for (int s = 0; s < NCONST; s++) begin
                v = grp_val(g, l, s);
                e[(l*NCONST+s)*XLEN +: XLEN] = {{48{v[15]}}, v};
            end
        return e;
    endfunction

    // driver: every slot of every lane holds a 16-bit integer at parcel == slot index
    task automatic build_group(input int g);
        clear_inputs();
        for (int l = 0; l < LANES; l++)
            for (int s = 0; s < NCONST; s++) begin
                in_raw[l*RAW_W + s*16 +: 16] = grp_val(g, l, s);
                in_pos[(l*NCONST+s)*4 +: 4]  = 4'(s);
                in_isz[(l*NCONST+s)*2 +: 2]  = 2'd1;
            end
        in_has = '1;
    endtask

    task automatic apply_vec(input int idx);
        int            lane, slot, sl;
        logic [RAW_W-1:0] raw_lane;
        logic [IW-1:0] e_imm;
        logic [NS-1:0] e_has, e_oob;
        lane = idx % LANES;
        slot = idx % NCONST;
        sl   = lane * NCONST + slot;
        @(negedge clk);
        clear_inputs();
        raw_lane = in_raw[lane*RAW_W +: RAW_W];
        for (int b = 0; b < 64; b++)
            if (b < (8 << vecs[idx].isz) && int'(vecs[idx].pos) * 16 + b < RAW_W)
                raw_lane[int'(vecs[idx].pos) * 16 + b] = vecs[idx].val[b];
        in_raw[lane*RAW_W +: RAW_W] = raw_lane;
        in_pos[sl*4 +: 4] = vecs[idx].pos;
        in_isz[sl*2 +: 2] = vecs[idx].isz;
        in_has[sl] = vecs[idx].has;
        in_fp[sl]  = vecs[idx].fp;
        in_valid   = 1'b1;
        e_imm = '0;
        e_imm[sl*XLEN +: XLEN] = vecs[idx].exp_imm;
        e_has = '0;
        e_has[sl] = vecs[idx].exp_has;
        e_oob = '0;
        e_oob[sl] = vecs[idx].exp_oob;
        #1 chk($sformatf("v%0d_in_ready", idx), in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk($sformatf("v%0d_latency_s1", idx), out_valid, 0);
        @(negedge clk);
        #1;
        chk($sformatf("v%0d_out_valid", idx), out_valid, 1);
        chk($sformatf("v%0d_imm", idx), out_imm, e_imm);
        chk($sformatf("v%0d_has", idx), out_has, e_has);
        chk($sformatf("v%0d_oob", idx), out_oob, e_oob);
        if (vecs[idx].exp_has) exp_cnt = exp_cnt + 1;
    endtask

    // streams n groups; out_ready is low during [stall_from, stall_from+stall_len)
    task automatic stream(input int n, input int base, input int stall_from, input int stall_len,
                          output logic saw_block);
        int         sent, got, cyc;
        logic [7:0] g;
        sent = 0; got = 0; cyc = 0; saw_block = 1'b0;
        exp_q.delete();
        while ((sent < n || got < n) && cyc < 60) begin
            @(negedge clk);
            out_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
            if (sent < n) begin
                build_group(base + sent);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("stream_unexpected_out", out_valid, 0);
                end else begin
                    g = exp_q.pop_front();
                    chk($sformatf("stream_g%0d_imm", g), out_imm, grp_exp(int'(g)));
                    chk($sformatf("stream_g%0d_has", g), out_has, {NS{1'b1}});
                    chk($sformatf("stream_g%0d_oob", g), out_oob, 0);
                    exp_cnt = exp_cnt + NS;
                end
                got++;
            end
            if (in_valid && !in_ready) saw_block = 1'b1;
            if (in_valid && in_ready) begin
                exp_q.push_back(8'(base + sent));
                sent++;
            end
            cyc++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_delivered", 32'(got), 32'(n));
        chk("stream_queue_empty", 32'(exp_q.size()), 0);
    endtask

    initial begin
        logic blocked, stray;
        vecs[0]  = '{4'd2,  2'd1, 1'b1, 1'b0, 64'h8001,               64'hFFFF_FFFF_FFFF_8001, 1'b1, 1'b0};
        vecs[1]  = '{4'd0,  2'd1, 1'b1, 1'b1, 64'h3C00,               64'h3FF0_0000_0000_0000, 1'b1, 1'b0};
        vecs[2]  = '{4'd3,  2'd2, 1'b1, 1'b1, 64'h4048_0000,          64'h4009_0000_0000_0000, 1'b1, 1'b0};
        vecs[3]  = '{4'd14, 2'd2, 1'b1, 1'b0, 64'h1234_5678,          64'h0,                   1'b0, 1'b1};
        vecs[4]  = '{4'd11, 2'd3, 1'b1, 1'b0, 64'h8123_4567_89AB_CDEF, 64'h8123_4567_89AB_CDEF, 1'b1, 1'b0};
        vecs[5]  = '{4'd13, 2'd3, 1'b1, 1'b0, 64'h1111,               64'h0,                   1'b0, 1'b1};
        vecs[6]  = '{4'd14, 2'd1, 1'b1, 1'b0, 64'h7FFF,               64'h7FFF,                1'b1, 1'b0};
        vecs[7]  = '{4'd15, 2'd0, 1'b1, 1'b0, 64'h55,                 64'h0,                   1'b0, 1'b1};
        vecs[8]  = '{4'd5,  2'd0, 1'b1, 1'b0, 64'h7F,                 64'h7F,                  1'b1, 1'b0};
        vecs[9]  = '{4'd6,  2'd0, 1'b1, 1'b0, 64'h80,                 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b0};
        vecs[10] = '{4'd0,  2'd2, 1'b1, 1'b0, 64'h8000_0000,          64'hFFFF_FFFF_8000_0000, 1'b1, 1'b0};
        vecs[11] = '{4'd14, 2'd3, 1'b0, 1'b0, 64'hDEAD,               64'h0,                   1'b0, 1'b0};
        vecs[12] = '{4'd7,  2'd3, 1'b1, 1'b1, 64'h4009_21FB_5444_2D18, 64'h4009_21FB_5444_2D18, 1'b1, 1'b0};
        vecs[13] = '{4'd9,  2'd0, 1'b1, 1'b1, 64'h90,                 64'hFFFF_FFFF_FFFF_FF90, 1'b1, 1'b0};
        vecs[14] = '{4'd1,  2'd1, 1'b1, 1'b1, 64'h0001,               64'h3E70_0000_0000_0000, 1'b1, 1'b0};
        vecs[15] = '{4'd4,  2'd1, 1'b1, 1'b1, 64'hC000,               64'hC000_0000_0000_0000, 1'b1, 1'b0};
        vecs[16] = '{4'd8,  2'd1, 1'b1, 1'b1, 64'h7C00,               64'h7FF0_0000_0000_0000, 1'b1, 1'b0};
        vecs[17] = '{4'd10, 2'd2, 1'b1, 1'b1, 64'h3F80_0000,          64'h3FF0_0000_0000_0000, 1'b1, 1'b0};
        vecs[18] = '{4'd1,  2'd2, 1'b1, 1'b1, 64'h0000_0001,          64'h36A0_0000_0000_0000, 1'b1, 1'b0};
        vecs[19] = '{4'd2,  2'd1, 1'b1, 1'b1, 64'h8000,               64'h8000_0000_0000_0000, 1'b1, 1'b0};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        clear_inputs();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_imm", out_imm, 0);
        chk("rst_out_has", out_has, 0);
        chk("rst_out_oob", out_oob, 0);
        chk("rst_const_cnt", const_cnt, 0);
        chk("rst_sat_cnt", sat_cnt, 32'hFFFF_FFF0);

        for (int v = 0; v < NV; v++) apply_vec(v);
        @(negedge clk);
        #1 chk("table_const_cnt", const_cnt, exp_cnt);

        stream(5, 0, 1, 3, blocked);
        chk("bp_in_ready_dropped", blocked, 1);
        #1 chk("bp_const_cnt", const_cnt, exp_cnt);

        // flush with both stages full; group 12 offered on the flush cycle
        @(negedge clk);
        out_ready = 1'b0; build_group(10); in_valid = 1'b1;
        #1 chk("fl_accept_g10", in_ready, 1);
        @(negedge clk);
        build_group(11);
        #1 chk("fl_accept_g11", in_ready, 1);
        @(negedge clk);
        flush = 1'b1; out_ready = 1'b1; build_group(12);
        #1;
        chk("fl_pre_out_valid", out_valid, 1);
        chk("fl_in_ready_low", in_ready, 0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1 chk("fl_out_valid_cleared", out_valid, 0);
        stray = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1 if (out_valid) stray = 1'b1;
        end
        chk("fl_no_stray_group", stray, 0);
        chk("fl_const_cnt", const_cnt, exp_cnt);

        // reset mid-operation, with a group offered during the reset cycle
        @(negedge clk);
        build_group(20); in_valid = 1'b1;
        @(negedge clk);
        build_group(21); rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        exp_cnt = 0;
        #1;
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_in_ready", in_ready, 1);
        chk("mrst_const_cnt", const_cnt, 0);
        chk("mrst_sat_cnt", sat_cnt, 32'hFFFF_FFF0);
        stray = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1 if (out_valid) stray = 1'b1;
        end
        chk("mrst_no_stray_group", stray, 0);

        stream(10, 0, 100, 0, blocked);
        #1;
        chk("cnt_120", const_cnt, 32'd120);
        chk("cnt_model", const_cnt, exp_cnt);
        chk("cnt_saturated", sat_cnt, 32'hFFFF_FFFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
